// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory read channel between the fetch sequencer and imem.
// The master (fetch side) owns the request and address; the slave returns
// the ack that marks read data valid for the presented address.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the imem request handshake,
// applies IF stalls, squashes wrong-path fetches and hands a validated
// fetch PC to IF/ID. Redirect priority is exception > jump > branch.
// Optional build macro PC_ALIGN_CHK_EN: a misaligned redirect target is
// turned into an exception redirect and reported on adel_if/bad_vaddr;
// without it the low two target bits are silently dropped.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_0040
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_if,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  input  logic                  jump,
  input  logic [31:0]           jump_target,
  input  logic                  exc_req,
  pc_fetch_ctrl_if.master       imem,
  output logic [31:0]           pc_if,
  output logic                  pc_valid,
  output logic                  flush_if
`ifdef PC_ALIGN_CHK_EN
  ,
  output logic                  adel_if,
  output logic [31:0]           bad_vaddr
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] pend_addr;
  logic        pend_vld;
  logic        kill;
  logic        redir;
  logic        capture_pend;
  logic [31:0] raw_target;
  logic [31:0] redir_target;

  assign redir = exc_req | jump | branch_taken;

  // Pick the redirect source by priority.
  always_comb begin
    // NOTE: the default assignment first guarantees every path drives
    // raw_target, so no latch is inferred when no redirect is active.
    raw_target = branch_target;
    if (exc_req) begin
      raw_target = EXC_VEC;
    end else if (jump) begin
      raw_target = jump_target;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  logic misaligned;
  assign misaligned   = redir && (raw_target[1:0] != 2'b00);
  assign redir_target = misaligned ? EXC_VEC : (raw_target & 32'hFFFF_FFFC);
`else
  assign redir_target = raw_target & 32'hFFFF_FFFC;
`endif

  assign imem.imem_req  = (state == ST_REQ);
  assign imem.imem_addr = addr_q;

  // A redirect that arrives while a fetch is in flight is parked here.
  assign capture_pend = (state == ST_REQ) && !imem.imem_ack && redir;

  // Pending redirect target; only meaningful while pend_vld is set.
  always_ff @(posedge clk) begin
    // NOTE: datapath register left out of reset on purpose: pend_vld,
    // which is reset, qualifies every read of it.
    if (capture_pend) begin
      pend_addr <= redir_target;
    end
  end

  // Fetch sequencer state, PC registers and one-cycle strobes.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout so every register samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      state    <= ST_IDLE;
      addr_q   <= RESET_PC;
      pc_if    <= RESET_PC;
      pc_valid <= 1'b0;
      flush_if <= 1'b0;
      pend_vld <= 1'b0;
      kill     <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
      adel_if   <= 1'b0;
      bad_vaddr <= 32'h0;
`endif
    end else begin
      pc_valid <= 1'b0;
      flush_if <= redir;
`ifdef PC_ALIGN_CHK_EN
      adel_if <= misaligned;
      if (misaligned) begin
        bad_vaddr <= raw_target;
      end
`endif
      case (state)
        ST_IDLE: begin
          state <= ST_REQ;
          if (redir) begin
            addr_q <= redir_target;
          end
        end
        ST_REQ: begin
          if (!imem.imem_ack) begin
            if (redir) begin
              pend_vld <= 1'b1;
              kill     <= 1'b1;
            end
          end else if (kill || redir) begin
            // Wrong-path data returns: drop it and steer to the newest target.
            if (redir) begin
              addr_q <= redir_target;
            end else if (pend_vld) begin
              addr_q <= pend_addr;
            end
            kill     <= 1'b0;
            pend_vld <= 1'b0;
          end else if (!stall_if) begin
            pc_valid <= 1'b1;
            pc_if    <= addr_q;
            addr_q   <= addr_q + 32'd4;
          end else begin
            pc_if <= addr_q;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redir) begin
            addr_q <= redir_target;
            state  <= ST_REQ;
          end else if (!stall_if) begin
            pc_valid <= 1'b1;
            addr_q   <= pc_if + 32'd4;
            state    <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC    = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exc_req;
  logic [31:0] pc_if;
  logic        pc_valid;
  logic        flush_if;
`ifdef PC_ALIGN_CHK_EN
  logic        adel_if;
  logic [31:0] bad_vaddr;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  pc_fetch_ctrl_if imem_bus ();

  pc_fetch_ctrl #(.RESET_PC(RST_PC), .EXC_VEC(EXC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exc_req       (exc_req),
    .imem          (imem_bus),
    .pc_if         (pc_if),
    .pc_valid      (pc_valid),
    .flush_if      (flush_if)
`ifdef PC_ALIGN_CHK_EN
    ,
    .adel_if       (adel_if),
    .bad_vaddr     (bad_vaddr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks whether a fetch is on the bus, whether a
  // fetched instruction is parked by a stall, and whether the in-flight
  // fetch is known to be wrong-path (with the address to go to instead).
  bit          m_on_bus      = 1'b0;
  bit          m_parked      = 1'b0;
  bit          m_wrong_path  = 1'b0;
  logic [31:0] m_redirect_to = 32'h0;
  logic        exp_req   = 1'b0;
  logic [31:0] exp_addr  = RST_PC;
  logic [31:0] exp_pc    = RST_PC;
  logic        exp_valid = 1'b0;
  logic        exp_flush = 1'b0;
  logic        exp_adel  = 1'b0;
  logic [31:0] exp_bad   = 32'h0;

  always @(posedge clk) begin
    logic        redir;
    logic        mis;
    logic [31:0] raw;
    logic [31:0] tgt;
    redir = exc_req | jump | branch_taken;
    raw   = exc_req ? EXC : (jump ? jump_target : branch_target);
    mis   = 1'b0;
`ifdef PC_ALIGN_CHK_EN
    mis = redir && (raw[1:0] != 2'b00);
`endif
    tgt = mis ? EXC : {raw[31:2], 2'b00};
    exp_valid = 1'b0;
    if (!rst) begin
      m_on_bus = 1'b0; m_parked = 1'b0; m_wrong_path = 1'b0;
      exp_addr = RST_PC; exp_pc = RST_PC;
      exp_flush = 1'b0; exp_adel = 1'b0; exp_bad = 32'h0;
    end else begin
      exp_flush = redir;
      exp_adel  = mis;
      if (mis) exp_bad = raw;
      if (m_parked) begin
        if (redir) begin
          m_parked = 1'b0; m_on_bus = 1'b1; exp_addr = tgt;
        end else if (!stall_if) begin
          m_parked = 1'b0; m_on_bus = 1'b1; exp_valid = 1'b1;
          exp_addr = exp_pc + 32'd4;
        end
      end else if (!m_on_bus) begin
        m_on_bus = 1'b1;
        if (redir) exp_addr = tgt;
      end else if (imem_bus.imem_ack) begin
        if (redir) exp_addr = tgt;
        else if (m_wrong_path) exp_addr = m_redirect_to;
        else if (!stall_if) begin
          exp_valid = 1'b1; exp_pc = exp_addr; exp_addr = exp_addr + 32'd4;
        end else begin
          exp_pc = exp_addr; m_parked = 1'b1; m_on_bus = 1'b0;
        end
        m_wrong_path = 1'b0;
      end else if (redir) begin
        m_wrong_path = 1'b1; m_redirect_to = tgt;
      end
    end
    exp_req = m_on_bus;
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_req",   imem_bus.imem_req,  exp_req);
      check("m_addr",  imem_bus.imem_addr, exp_addr);
      check("m_valid", pc_valid, exp_valid);
      check("m_pc_if", pc_if,    exp_pc);
      check("m_flush", flush_if, exp_flush);
`ifdef PC_ALIGN_CHK_EN
      check("m_adel",  adel_if,   exp_adel);
      check("m_bad",   bad_vaddr, exp_bad);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; stall_if = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; exc_req = 1'b0; imem_bus.imem_ack = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    tick(); tick();
    check("rst_req",   imem_bus.imem_req, 1'b0);
    check("rst_addr",  imem_bus.imem_addr, 32'h0);
    check("rst_pc_if", pc_if, 32'h0);
    check("rst_valid", pc_valid, 1'b0);
    check("rst_flush", flush_if, 1'b0);

    // Sequential fetch with single-cycle ack.
    rst = 1'b1; imem_bus.imem_ack = 1'b1;
    tick();
    check("t1_req", imem_bus.imem_req, 1'b1);
    check("t1_addr0", imem_bus.imem_addr, 32'h0);
    check("t1_valid0", pc_valid, 1'b0);
    tick();
    check("t1_valid1", pc_valid, 1'b1);
    check("t1_pc0", pc_if, 32'h0);
    check("t1_addr4", imem_bus.imem_addr, 32'h4);
    tick();
    check("t1_pc4", pc_if, 32'h4);
    check("t1_addr8", imem_bus.imem_addr, 32'h8);

    // Branch while 0x8 is outstanding, ack delayed three cycles.
    imem_bus.imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    check("t2_flush", flush_if, 1'b1);
    check("t2_hold_addr", imem_bus.imem_addr, 32'h8);
    branch_taken = 1'b0;
    tick(); tick();
    check("t2_wait_valid", pc_valid, 1'b0);
    imem_bus.imem_ack = 1'b1;
    tick();
    check("t2_killed", pc_valid, 1'b0);
    check("t2_target", imem_bus.imem_addr, 32'h100);
    tick();
    check("t2_pc100", pc_if, 32'h100);
    check("t2_valid", pc_valid, 1'b1);

    // Simultaneous exception, jump and branch.
    exc_req = 1'b1; jump = 1'b1; jump_target = 32'h200;
    branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    check("t3_addr", imem_bus.imem_addr, 32'h40);
    check("t3_flush", flush_if, 1'b1);
    exc_req = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    tick();
    check("t3_flush_once", flush_if, 1'b0);
    check("t3_pc40", pc_if, 32'h40);

    // Stall on ack of 0x10 for four cycles.
    jump = 1'b1; jump_target = 32'h10;
    tick();
    jump = 1'b0; stall_if = 1'b1;
    tick();
    check("t4_hold_req", imem_bus.imem_req, 1'b0);
    check("t4_hold_pc", pc_if, 32'h10);
    repeat (3) begin
      tick();
      check("t4_hold_valid", pc_valid, 1'b0);
    end
    stall_if = 1'b0;
    tick();
    check("t4_rel_valid", pc_valid, 1'b1);
    check("t4_rel_pc", pc_if, 32'h10);
    check("t4_rel_addr", imem_bus.imem_addr, 32'h14);

    // Address wrap.
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    check("t5_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
    jump = 1'b0;
    tick();
    check("t5_wrap", imem_bus.imem_addr, 32'h0);
    check("t5_pc", pc_if, 32'hFFFF_FFFC);

    // Reset mid-request, stale ack afterwards.
    imem_bus.imem_ack = 1'b0;
    tick();
    rst = 1'b0; imem_bus.imem_ack = 1'b1;
    tick(); tick();
    check("t6_req", imem_bus.imem_req, 1'b0);
    check("t6_pc", pc_if, 32'h0);
    rst = 1'b1;
    tick();
    check("t6_refetch_valid", pc_valid, 1'b0);
    check("t6_refetch_addr", imem_bus.imem_addr, 32'h0);
    tick();
    check("t6_first", pc_valid, 1'b1);

`ifdef PC_ALIGN_CHK_EN
    jump = 1'b1; jump_target = 32'h102;
    tick();
    check("al_adel", adel_if, 1'b1);
    check("al_bad", bad_vaddr, 32'h102);
    check("al_addr", imem_bus.imem_addr, 32'h40);
    jump = 1'b0;
    tick();
    check("al_adel_pulse", adel_if, 1'b0);
`endif

    // Randomized traffic, checked by the model every cycle.
    repeat (4000) begin
      rst           = ($urandom_range(0, 99) != 0);
      stall_if      = ($urandom_range(0, 3) == 0);
      imem_bus.imem_ack = ($urandom_range(0, 2) != 0);
      exc_req       = ($urandom_range(0, 23) == 0);
      jump          = ($urandom_range(0, 11) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jump_target   = $urandom;
      branch_target = $urandom;
      tick();
    end
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
